// File: rtl/exp_series_controller_pkg.sv
// Shared definitions for the exponential-series controller.
// Contents:
//   state_t          - FSM state encoding (3-bit binary)
//   ONE              - Q8.8 constant 1.0 used by the datapath initialisers
//   INDEX_W/TERMS_W  - widths of the LUT index and the terms-added count
//   MAX_TERMS_MIN/MAX - legal range of the MAX_TERMS parameter
//   max_terms_legal  - helper that checks a MAX_TERMS value against that range
package exp_series_controller_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    MULX = 3'd2,
    MULR = 3'd3,
    CMP  = 3'd4,
    ADD  = 3'd5,
    DONE = 3'd6
  } state_t;

  localparam logic [15:0] ONE = 16'h0100;

  localparam int INDEX_W       = 4;
  localparam int TERMS_W       = 5;
  localparam int MAX_TERMS_MIN = 1;
  localparam int MAX_TERMS_MAX = 16;

  function automatic bit max_terms_legal(input int n);
    return (n >= MAX_TERMS_MIN) && (n <= MAX_TERMS_MAX);
  endfunction

endpackage

// File: rtl/exp_series_controller_if.sv
// Bundle of every controller signal other than clock and reset.
// Handshake: the host raises start while ready is high; the request is taken
// on the rising edge where the controller is in IDLE (ready=1) and start=1.
// done is a single-cycle pulse marking the datapath result as valid; the
// host may hold start through done to chain the next request.
// Modports:
//   master - the controller: consumes start/alt/less, drives everything else
//   slave  - host and datapath side: drives start/alt/less, observes the rest
// dbg_state exposes the FSM state for observation.
interface exp_series_controller_if;
  import exp_series_controller_pkg::*;

  // host side
  logic               start;
  logic               alt;
  logic               ready;
  logic               done;
  logic [TERMS_W-1:0] terms_used;
  // datapath side
  logic               less;
  logic               ld_x;
  logic               ld_y;
  logic               iz_term;
  logic               iz_ans;
  logic               ld_term;
  logic               mux_sel;
  logic               ld_ans;
  logic               neg;
  logic [INDEX_W-1:0] index;
  // observation
  state_t             dbg_state;

  modport master (
    input  start, alt, less,
    output ready, done, terms_used,
    output ld_x, ld_y, iz_term, iz_ans, ld_term, mux_sel, ld_ans, neg, index,
    output dbg_state
  );

  modport slave (
    output start, alt, less,
    input  ready, done, terms_used,
    input  ld_x, ld_y, iz_term, iz_ans, ld_term, mux_sel, ld_ans, neg, index,
    input  dbg_state
  );

endinterface

// File: rtl/exp_series_controller_term_counter.sv
// Term bookkeeping for the series controller.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   clr         - zero index and terms_used (start of a new series)
//   inc         - one term has been added: terms_used+1, index advances
//                 unless it already addresses the last term
//   index       - LUT address, current term number minus 1
//   terms_used  - number of terms added so far (0..MAX_TERMS)
//   last        - index is addressing term MAX_TERMS
module exp_series_controller_term_counter
  import exp_series_controller_pkg::*;
#(
  parameter int MAX_TERMS = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               inc,
  output logic [INDEX_W-1:0] index,
  output logic [TERMS_W-1:0] terms_used,
  output logic               last
);

  localparam logic [INDEX_W-1:0] LAST_IDX = INDEX_W'(MAX_TERMS - 1);

  assign last = (index == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      index      <= '0;
      terms_used <= '0;
    end else if (clr) begin
      index      <= '0;
      terms_used <= '0;
    end else if (inc) begin
      terms_used <= terms_used + TERMS_W'(1);
      // Holding on the last term keeps index at MAX_TERMS-1 after the series
      // ends, so it never wraps even when MAX_TERMS is 16.
      if (!last) index <= index + INDEX_W'(1);
    end
  end

endmodule

// File: rtl/exp_series_controller.sv
// Moore controller that sequences the Q8.8 exponential-series datapath:
// load operands, set term=ans=1.0, then per term multiply by x, multiply by
// 1/n from the LUT, compare against y, and add (or subtract) into ans.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset; returns to IDLE from any state
//   bus    - exp_series_controller_if.master (host handshake, datapath
//            controls, comparator input, state observation)
// Parameter MAX_TERMS (1..16): series terms added after the constant 1.0.
module exp_series_controller
  import exp_series_controller_pkg::*;
#(
  parameter int MAX_TERMS = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  exp_series_controller_if.master   bus
);

  state_t             state;
  logic               alt_q;
  logic               cnt_last;
  logic [INDEX_W-1:0] index;
  logic [TERMS_W-1:0] terms_used;

  exp_series_controller_term_counter #(
    .MAX_TERMS (MAX_TERMS)
  ) u_term_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (state == LOAD),
    .inc        (state == ADD),
    .index      (index),
    .terms_used (terms_used),
    .last       (cnt_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      alt_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) state <= LOAD;
        LOAD: begin
          alt_q <= bus.alt;
          state <= MULX;
        end
        MULX: state <= MULR;
        MULR: state <= CMP;
        // The freshly formed term is already below y: it is dropped, not added.
        CMP:  state <= bus.less ? DONE : ADD;
        ADD:  state <= cnt_last ? DONE : MULX;
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Output decode depends only on registered state, so every output is a
  // clean function of registers and reset takes effect combinationally.
  always_comb begin
    bus.ready   = 1'b0;
    bus.done    = 1'b0;
    bus.ld_x    = 1'b0;
    bus.ld_y    = 1'b0;
    bus.iz_term = 1'b0;
    bus.iz_ans  = 1'b0;
    bus.ld_term = 1'b0;
    bus.mux_sel = 1'b0;
    bus.ld_ans  = 1'b0;
    bus.neg     = 1'b0;
    case (state)
      IDLE: bus.ready = 1'b1;
      LOAD: begin
        bus.ld_x    = 1'b1;
        bus.ld_y    = 1'b1;
        bus.iz_term = 1'b1;
        bus.iz_ans  = 1'b1;
      end
      MULX: bus.ld_term = 1'b1;
      MULR: begin
        bus.ld_term = 1'b1;
        bus.mux_sel = 1'b1;
      end
      ADD: begin
        bus.ld_ans = 1'b1;
        // Term k = index+1 carries a minus sign for odd k in e^-x.
        bus.neg    = alt_q & ~index[0];
      end
      DONE: bus.done = 1'b1;
      default: ;
    endcase
  end

  assign bus.index      = index;
  assign bus.terms_used = terms_used;
  assign bus.dbg_state  = state;

endmodule

// File: tb/tb_exp_series_controller.sv
// Bench for exp_series_controller (MAX_TERMS=4). The bench plays the datapath
// comparator: less rises once the configured number of MULR steps has run.
module tb_exp_series_controller;
  import exp_series_controller_pkg::*;

  localparam int MT = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_series_controller_if bus_if ();

  exp_series_controller #(.MAX_TERMS(MT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  // ---------------- comparator model ----------------
  int stop_at = 99;  // CMP number (1-based) at which term < y
  int mulr_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mulr_cnt <= 0;
    else if (bus_if.ld_x) mulr_cnt <= 0;
    else if (bus_if.ld_term && bus_if.mux_sel) mulr_cnt <= mulr_cnt + 1;
  end
  assign bus_if.less = (mulr_cnt >= stop_at);

  // ---------------- scoreboard ----------------
  // exp_q entry: {latency[7:0], terms_used[4:0], final index[3:0]}
  logic [16:0] exp_q[$];
  // add_q entry: {neg, index[3:0]} for each expected ld_ans
  logic [4:0]  add_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: series stops at the first CMP reporting less, or after MT adds.
  task automatic push_expect(input bit a, input int stop);
    int terms, lat, idx;
    bit early;
    early = (stop <= MT);
    terms = early ? stop - 1 : MT;
    lat   = early ? 1 + 4 * terms + 4 : 1 + 4 * MT + 1;
    idx   = early ? terms : MT - 1;
    exp_q.push_back({8'(lat), 5'(terms), 4'(idx)});
    for (int k = 1; k <= terms; k++)
      add_q.push_back({a && (k % 2 == 1), 4'(k - 1)});
  endtask

  // ---------------- monitor ----------------
  initial begin
    int load_cyc, n_add, n_mulr;
    bit prev_done;
    logic [16:0] e;
    logic [4:0] a;
    load_cyc = 0; n_add = 0; n_mulr = 0; prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_done = 1'b0;
        continue;
      end
      if (bus_if.ld_x) begin
        check("load_expected", int'(exp_q.size() > 0), 1);
        check("load_all_ctl", {bus_if.ld_y, bus_if.iz_term, bus_if.iz_ans}, 3'b111);
        load_cyc = cyc; n_add = 0; n_mulr = 0;
      end
      if (bus_if.ld_term && bus_if.mux_sel) begin
        check("mulr_index", bus_if.index, n_mulr);
        n_mulr++;
      end
      if (bus_if.ld_ans) begin
        n_add++;
        if (add_q.size() == 0) check("add_expected", 0, 1);
        else begin
          a = add_q.pop_front();
          check("add_index", bus_if.index, a[3:0]);
          check("add_neg", bus_if.neg, a[4]);
        end
      end
      if (bus_if.done) begin
        check("done_single", prev_done, 0);
        if (exp_q.size() == 0) check("done_expected", 0, 1);
        else begin
          e = exp_q.pop_front();
          check("latency", cyc - load_cyc + 1, e[16:9]);
          check("terms_used", bus_if.terms_used, e[8:4]);
          check("done_index", bus_if.index, e[3:0]);
          check("add_count", n_add, e[8:4]);
        end
      end
      prev_done = bus_if.done;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ready();
    int n = 0;
    while (!bus_if.ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus_if.ready) check("ready_timeout", 0, 1);
  endtask

  // Issue one request, then wiggle start/alt while busy (both must be ignored).
  task automatic run_txn(input bit a, input int stop, input bit noise);
    wait_ready();
    bus_if.start = 1'b1;
    bus_if.alt   = a;
    stop_at      = stop;
    push_expect(a, stop);
    @(negedge clk);
    bus_if.start = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (bus_if.ready) break;
      bus_if.alt = 1'($urandom);
      if (noise) bus_if.start = ($urandom_range(0, 3) == 0);
    end
    bus_if.start = 1'b0;
  endtask

  task automatic held_start_test();
    int n;
    wait_ready();
    bus_if.start = 1'b1;
    bus_if.alt   = 1'b0;
    stop_at      = 2;
    push_expect(1'b0, 2);
    @(negedge clk);
    bus_if.start = 1'b0;
    n = 0;
    while (!bus_if.done && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("held_done_seen", bus_if.done, 1);
    bus_if.start = 1'b1;
    push_expect(1'b0, 1);
    @(negedge clk);
    stop_at = 1;
    check("held_ready", bus_if.ready, 1);
    check("held_no_load", bus_if.ld_x, 0);
    @(negedge clk);
    check("held_load", bus_if.ld_x, 1);
    bus_if.start = 1'b0;
    @(negedge clk);
    wait_ready();
  endtask

  task automatic reset_test();
    int n;
    wait_ready();
    bus_if.start = 1'b1;
    bus_if.alt   = 1'b1;
    stop_at      = 99;
    push_expect(1'b1, 99);
    @(negedge clk);
    bus_if.start = 1'b0;
    n = 0;
    while (!(bus_if.ld_term && bus_if.mux_sel && bus_if.index == 4'd1) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("rst_reached_mulr", bus_if.mux_sel, 1);
    rst_n = 1'b0;
    #1;
    check("rst_ready", bus_if.ready, 1);
    check("rst_ctl", {bus_if.ld_term, bus_if.mux_sel, bus_if.ld_ans, bus_if.done, bus_if.neg}, 0);
    check("rst_index", bus_if.index, 0);
    check("rst_terms", bus_if.terms_used, 0);
    exp_q.delete();
    add_q.delete();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    bus_if.start = 1'b0;
    bus_if.alt   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("init_ready", bus_if.ready, 1);
    check("init_ctl", {bus_if.ld_x, bus_if.ld_term, bus_if.ld_ans, bus_if.done, bus_if.neg}, 0);
    check("init_terms", bus_if.terms_used, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_txn(1'b0, 1, 1'b0);   // immediate convergence: done in cycle 5
    run_txn(1'b0, 99, 1'b1);  // max terms: done in cycle 18
    run_txn(1'b1, 3, 1'b1);   // alternating sign, stops at third CMP
    held_start_test();
    reset_test();
    run_txn(1'b0, 2, 1'b0);   // normal run after reset
    for (int i = 0; i < 30; i++)
      run_txn(1'($urandom), $urandom_range(1, MT + 2), 1'($urandom));

    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_exp", exp_q.size(), 0);
    check("drain_add", add_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
